// File: rtl/bp_be_pipe_aux_raw.sv
// Backend FP auxiliary pipe on raw IEEE-754 operands: sign injection, min/max, compares,
// classify and moves, computed in stage one then retimed, with flush and sticky fflags.
module bp_be_pipe_aux_raw #(
  parameter int unsigned latency_p     = 2,
  parameter int unsigned dword_width_p = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic [3:0]               fu_op_i,
  input  logic                     ops_v_i,
  input  logic [dword_width_p-1:0] rs1_i,
  input  logic [dword_width_p-1:0] rs2_i,
  input  logic                     flush_i,
  input  logic                     fflags_clr_i,
  output logic                     v_o,
  output logic [dword_width_p-1:0] data_o,
  output logic                     int_not_fp_o,
  output logic [4:0]               fflags_o,
  output logic [4:0]               fflags_acc_o
);

  typedef enum logic [3:0] {
    OpFsgnj  = 4'd0,
    OpFsgnjn = 4'd1,
    OpFsgnjx = 4'd2,
    OpFmin   = 4'd3,
    OpFmax   = 4'd4,
    OpFeq    = 4'd5,
    OpFlt    = 4'd6,
    OpFle    = 4'd7,
    OpFclass = 4'd8,
    OpFmvi   = 4'd9,
    OpImvf   = 4'd10
  } aux_op_e;

  typedef struct packed {
    logic        sign;
    logic        inf;
    logic        nan;
    logic        snan;
    logic        zero;
    logic        sub;
    logic        norm;
    logic [62:0] mag;
  } fp_info_t;

  function automatic fp_info_t decode(input logic sp, input logic [63:0] x);
    fp_info_t info;
    logic exp_max, exp_zero, man_zero, quiet;
    if (sp) begin
      info.sign = x[31];
      info.mag  = {32'b0, x[30:0]};
      exp_max   = &x[30:23];
      exp_zero  = ~|x[30:23];
      man_zero  = ~|x[22:0];
      quiet     = x[22];
    end else begin
      info.sign = x[63];
      info.mag  = x[62:0];
      exp_max   = &x[62:52];
      exp_zero  = ~|x[62:52];
      man_zero  = ~|x[51:0];
      quiet     = x[51];
    end
    info.inf  = exp_max & man_zero;
    info.nan  = exp_max & ~man_zero;
    info.snan = info.nan & ~quiet;
    info.zero = exp_zero & man_zero;
    info.sub  = exp_zero & ~man_zero;
    info.norm = ~exp_zero & ~exp_max;
    return info;
  endfunction

  function automatic logic [63:0] box(input logic sp, input logic [63:0] x);
    return sp ? {32'hFFFF_FFFF, x[31:0]} : x;
  endfunction

  logic [63:0] a, b, canon_nan;
  logic        unbox_en;
  fp_info_t    ia, ib;
  logic        any_nan, any_snan, both_zero, lt, feq, flt;
  logic        sgn;
  logic [63:0] res_data;
  logic        res_int;
  logic [4:0]  res_flags;

  always_comb begin
    unbox_en  = (fu_op_i <= OpFclass);
    a         = (unbox_en && ops_v_i && (rs1_i[63:32] != 32'hFFFF_FFFF)) ? 64'h7FC0_0000 : rs1_i;
    b         = (unbox_en && ops_v_i && (rs2_i[63:32] != 32'hFFFF_FFFF)) ? 64'h7FC0_0000 : rs2_i;
    ia        = decode(ops_v_i, a);
    ib        = decode(ops_v_i, b);
    canon_nan = ops_v_i ? 64'hFFFF_FFFF_7FC0_0000 : 64'h7FF8_0000_0000_0000;

    any_nan   = ia.nan | ib.nan;
    any_snan  = ia.snan | ib.snan;
    both_zero = ia.zero & ib.zero;
    // Sign-magnitude total order; places -0 below +0 as fmin/fmax require.
    if (ia.sign != ib.sign) lt = ia.sign;
    else if (ia.sign)       lt = ib.mag < ia.mag;
    else                    lt = ia.mag < ib.mag;
    feq = ~any_nan & (((ia.sign == ib.sign) && (ia.mag == ib.mag)) | both_zero);
    flt = ~any_nan & lt & ~both_zero;

    res_data  = '0;
    res_int   = 1'b0;
    res_flags = '0;
    sgn       = 1'b0;
    case (fu_op_i)
      OpFsgnj, OpFsgnjn, OpFsgnjx: begin
        if (fu_op_i == OpFsgnj)       sgn = ib.sign;
        else if (fu_op_i == OpFsgnjn) sgn = ~ib.sign;
        else                          sgn = ia.sign ^ ib.sign;
        res_data = ops_v_i ? {32'hFFFF_FFFF, sgn, a[30:0]} : {sgn, a[62:0]};
      end
      OpFmin, OpFmax: begin
        res_flags[4] = any_snan;
        if (ia.nan && ib.nan)        res_data = canon_nan;
        else if (ia.nan)             res_data = box(ops_v_i, b);
        else if (ib.nan)             res_data = box(ops_v_i, a);
        else if (fu_op_i == OpFmin)  res_data = box(ops_v_i, lt ? a : b);
        else                         res_data = box(ops_v_i, lt ? b : a);
      end
      OpFeq: begin
        res_int      = 1'b1;
        res_flags[4] = any_snan;
        res_data     = {63'b0, feq};
      end
      OpFlt, OpFle: begin
        res_int      = 1'b1;
        res_flags[4] = any_nan;
        res_data     = {63'b0, (fu_op_i == OpFlt) ? flt : (flt | feq)};
      end
      OpFclass: begin
        res_int  = 1'b1;
        res_data = {54'b0,
                    ia.nan & ~ia.snan, ia.snan,
                    ~ia.sign & ia.inf, ~ia.sign & ia.norm, ~ia.sign & ia.sub, ~ia.sign & ia.zero,
                    ia.sign & ia.zero, ia.sign & ia.sub, ia.sign & ia.norm, ia.sign & ia.inf};
      end
      OpFmvi: begin
        res_int  = 1'b1;
        res_data = ops_v_i ? {{32{rs1_i[31]}}, rs1_i[31:0]} : rs1_i;
      end
      OpImvf: res_data = box(ops_v_i, rs1_i);
      default: res_int = 1'b1;
    endcase
  end

  logic [latency_p-1:0]     v_q;
  logic [63:0]              data_q  [latency_p];
  logic [latency_p-1:0]     int_q;
  logic [4:0]               flags_q [latency_p];
  logic [4:0]               acc_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q   <= '0;
      int_q <= '0;
      for (int i = 0; i < int'(latency_p); i++) begin
        data_q[i]  <= '0;
        flags_q[i] <= '0;
      end
    end else begin
      v_q[0]     <= v_i & ~flush_i;
      data_q[0]  <= res_data;
      int_q[0]   <= res_int;
      flags_q[0] <= res_flags;
      for (int i = 1; i < int'(latency_p); i++) begin
        v_q[i]     <= v_q[i-1] & ~flush_i;
        data_q[i]  <= data_q[i-1];
        int_q[i]   <= int_q[i-1];
        flags_q[i] <= flags_q[i-1];
      end
    end
  end

  always_comb begin
    v_o          = v_q[latency_p-1];
    data_o       = v_o ? data_q[latency_p-1] : '0;
    int_not_fp_o = v_o & int_q[latency_p-1];
    fflags_o     = v_o ? flags_q[latency_p-1] : '0;
    fflags_acc_o = acc_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)                   acc_q <= '0;
    else if (fflags_clr_i && v_o)  acc_q <= fflags_o;
    else if (fflags_clr_i)         acc_q <= '0;
    else if (v_o)                  acc_q <= acc_q | fflags_o;
  end

endmodule

// File: tb/tb_bp_be_pipe_aux_raw.sv
// Directed plus randomized bench for bp_be_pipe_aux_raw against a value-level reference model.
module tb_bp_be_pipe_aux_raw;
  localparam int LAT = 3;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        reset_i, v_i, ops_v_i, flush_i, fflags_clr_i;
  logic [3:0]  fu_op_i;
  logic [63:0] rs1_i, rs2_i;
  logic        v_o, int_not_fp_o;
  logic [63:0] data_o;
  logic [4:0]  fflags_o, fflags_acc_o;

  bp_be_pipe_aux_raw #(.latency_p(LAT), .dword_width_p(64)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .fu_op_i(fu_op_i), .ops_v_i(ops_v_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i), .fflags_clr_i(fflags_clr_i),
    .v_o(v_o), .data_o(data_o), .int_not_fp_o(int_not_fp_o), .fflags_o(fflags_o),
    .fflags_acc_o(fflags_acc_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit checks_on = 0;
  bit        exp_v [MAXC];
  bit [63:0] exp_d [MAXC];
  bit        exp_i [MAXC];
  bit [4:0]  exp_f [MAXC];
  bit [4:0]  acc_exp = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s cycle %0d: got %h want %h", tag, cyc, obs, expv);
    end
  endtask

  // ---------------- reference model (value level) ----------------
  function automatic bit [63:0] mag(input bit sp, input bit [63:0] x);
    return sp ? {33'b0, x[30:0]} : {1'b0, x[62:0]};
  endfunction
  function automatic bit sgn(input bit sp, input bit [63:0] x);
    return sp ? x[31] : x[63];
  endfunction
  function automatic bit [63:0] inf_mag(input bit sp);
    return sp ? 64'h7F80_0000 : 64'h7FF0_0000_0000_0000;
  endfunction
  function automatic bit is_nan(input bit sp, input bit [63:0] x);
    return mag(sp, x) > inf_mag(sp);
  endfunction
  function automatic bit is_snan(input bit sp, input bit [63:0] x);
    return is_nan(sp, x) && !(sp ? x[22] : x[51]);
  endfunction
  function automatic bit less(input bit sp, input bit [63:0] a, input bit [63:0] b);
    longint ka, kb;
    ka = sgn(sp, a) ? -longint'(mag(sp, a)) : longint'(mag(sp, a));
    kb = sgn(sp, b) ? -longint'(mag(sp, b)) : longint'(mag(sp, b));
    return (ka < kb) || (ka == kb && sgn(sp, a) && !sgn(sp, b));
  endfunction
  function automatic bit [63:0] bx(input bit sp, input bit [63:0] x);
    return sp ? {32'hFFFF_FFFF, x[31:0]} : x;
  endfunction

  task automatic ref_op(input bit [3:0] op, input bit sp, input bit [63:0] r1, input bit [63:0] r2,
                        output bit [63:0] d, output bit [4:0] f, output bit io);
    bit [63:0] a, b, m, minnorm;
    bit s, za, zb, na, nb;
    int k;
    a = r1; b = r2;
    if (sp && op <= 8 && r1[63:32] != 32'hFFFF_FFFF) a = 64'h7FC0_0000;
    if (sp && op <= 8 && r2[63:32] != 32'hFFFF_FFFF) b = 64'h7FC0_0000;
    na = is_nan(sp, a); nb = is_nan(sp, b);
    za = mag(sp, a) == 0; zb = mag(sp, b) == 0;
    d = 0; f = 0; io = (op >= 5 && op <= 9) || op > 10;
    case (op)
      0, 1, 2: begin
        s = (op == 0) ? sgn(sp, b) : (op == 1) ? !sgn(sp, b) : sgn(sp, a) ^ sgn(sp, b);
        d = sp ? {32'hFFFF_FFFF, s, a[30:0]} : {s, a[62:0]};
      end
      3, 4: begin
        f[4] = is_snan(sp, a) || is_snan(sp, b);
        if (na && nb) d = sp ? 64'hFFFF_FFFF_7FC0_0000 : 64'h7FF8_0000_0000_0000;
        else if (na) d = bx(sp, b);
        else if (nb) d = bx(sp, a);
        else if (op == 3) d = bx(sp, less(sp, b, a) ? b : a);
        else d = bx(sp, less(sp, a, b) ? b : a);
      end
      5: begin
        f[4] = is_snan(sp, a) || is_snan(sp, b);
        d = !na && !nb && ((za && zb) || bx(sp, a) == bx(sp, b));
      end
      6, 7: begin
        f[4] = na || nb;
        if (!na && !nb)
          d = (op == 6) ? (less(sp, a, b) && !(za && zb))
                        : (less(sp, a, b) || (za && zb) || bx(sp, a) == bx(sp, b));
      end
      8: begin
        m = mag(sp, a);
        minnorm = sp ? 64'h0080_0000 : 64'h0010_0000_0000_0000;
        if (na) k = is_snan(sp, a) ? 8 : 9;
        else if (m == inf_mag(sp)) k = sgn(sp, a) ? 0 : 7;
        else if (m == 0) k = sgn(sp, a) ? 3 : 4;
        else if (m < minnorm) k = sgn(sp, a) ? 2 : 5;
        else k = sgn(sp, a) ? 1 : 6;
        d = 64'd1 << k;
      end
      9: d = sp ? 64'(signed'(r1[31:0])) : r1;
      10: d = bx(sp, r1);
      default: d = 0;
    endcase
  endtask

  // One clock: check this cycle's outputs, then drive the next inputs and advance the model.
  task automatic tick(input bit vv, input bit [3:0] op, input bit sp, input bit [63:0] a,
                      input bit [63:0] b, input bit fl, input bit clr, input bit rst);
    bit [63:0] d; bit [4:0] f; bit io;
    @(negedge clk);
    if (checks_on) begin
      chk("v_o", 64'(v_o), 64'(exp_v[cyc]));
      chk("data_o", data_o, exp_v[cyc] ? exp_d[cyc] : 64'd0);
      chk("int_not_fp_o", 64'(int_not_fp_o), 64'(exp_v[cyc] & exp_i[cyc]));
      chk("fflags_o", 64'(fflags_o), exp_v[cyc] ? 64'(exp_f[cyc]) : 64'd0);
      chk("fflags_acc_o", 64'(fflags_acc_o), 64'(acc_exp));
    end
    v_i = vv; fu_op_i = op; ops_v_i = sp; rs1_i = a; rs2_i = b;
    flush_i = fl; fflags_clr_i = clr; reset_i = rst;
    if (rst) acc_exp = 0;
    else if (clr && exp_v[cyc]) acc_exp = exp_f[cyc];
    else if (clr) acc_exp = 0;
    else if (exp_v[cyc]) acc_exp = acc_exp | exp_f[cyc];
    if (rst || fl) for (int i = 1; i <= LAT; i++) exp_v[cyc+i] = 0;
    if (vv && !fl && !rst) begin
      ref_op(op, sp, a, b, d, f, io);
      exp_v[cyc+LAT] = 1; exp_d[cyc+LAT] = d; exp_f[cyc+LAT] = f; exp_i[cyc+LAT] = io;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic bit [63:0] rand_val(input bit sp);
    bit [63:0] x;
    bit [31:0] s;
    case ($urandom_range(0, 7))
      0: x = sp ? 64'h0 : 64'h0;
      1: x = sp ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
      2: x = sp ? {32'b0, $urandom_range(0, 1) == 1, 31'h7F80_0000}
                : {$urandom_range(0, 1) == 1, 63'h7FF0_0000_0000_0000};
      3: x = sp ? 64'h7FC0_0001 : 64'h7FF8_0000_0000_0001;
      4: x = sp ? 64'hFF80_0003 : 64'hFFF0_0000_0000_0005;
      5: x = sp ? {32'b0, 1'($urandom), 8'h0, 23'($urandom)}
                : {1'($urandom), 11'h0, 20'($urandom), 32'($urandom)};
      default: x = {32'($urandom), 32'($urandom)};
    endcase
    if (sp) begin
      s = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'hFFFF_FFFF;
      x = {s, x[31:0]};
    end
    return x;
  endfunction

  int seen;

  initial begin
    reset_i = 1; v_i = 0; fu_op_i = 0; ops_v_i = 0; rs1_i = 0; rs2_i = 0;
    flush_i = 0; fflags_clr_i = 0;
    tick(0, 0, 0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 0, 1);
    checks_on = 1;
    idle(2);
    chk("reset_v_o", 64'(v_o), 64'd0);
    chk("reset_acc", 64'(fflags_acc_o), 64'd0);

    // DP fmin(-0, +0) -> -0
    tick(1, 3, 0, 64'h8000_0000_0000_0000, 64'h0, 0, 0, 0);
    idle(LAT);
    chk("fmin_zero_v", 64'(v_o), 64'd1);
    chk("fmin_zero_data", data_o, 64'h8000_0000_0000_0000);
    chk("fmin_zero_int", 64'(int_not_fp_o), 64'd0);

    // SP feq / flt with an sNaN operand
    tick(1, 5, 1, 64'hFFFF_FFFF_7F80_0001, 64'hFFFF_FFFF_3F80_0000, 0, 0, 0);
    tick(1, 6, 1, 64'hFFFF_FFFF_7F80_0001, 64'hFFFF_FFFF_3F80_0000, 0, 0, 0);
    idle(LAT - 1);
    chk("feq_snan_data", data_o, 64'd0);
    chk("feq_snan_flags", 64'(fflags_o), 64'h10);
    idle(1);
    chk("flt_snan_flags", 64'(fflags_o), 64'h10);

    // SP fsgnjn with an unboxed rs1
    tick(1, 1, 1, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_0000_0000, 0, 0, 0);
    idle(LAT);
    chk("fsgnjn_unbox", data_o, 64'hFFFF_FFFF_FFC0_0000);

    // Four ops back to back, flush with the third: only the fourth retires
    idle(LAT);
    tick(1, 9, 0, 64'h11, 0, 0, 0, 0);
    tick(1, 9, 0, 64'h22, 0, 0, 0, 0);
    tick(1, 9, 0, 64'h33, 0, 1, 0, 0);
    tick(1, 9, 0, 64'h44, 0, 0, 0, 0);
    seen = 0;
    for (int i = 0; i < LAT; i++) begin
      idle(1);
      seen += int'(v_o);
    end
    chk("flush_retire_count", 64'(seen), 64'd1);
    chk("flush_survivor", data_o, 64'h44);

    // Sticky accumulator with clear alongside the second retirement
    tick(0, 0, 0, 0, 0, 0, 1, 0);
    tick(1, 6, 1, 64'hFFFF_FFFF_7FC0_0000, 64'hFFFF_FFFF_3F80_0000, 0, 0, 0);
    tick(1, 6, 1, 64'hFFFF_FFFF_7FC0_0000, 64'hFFFF_FFFF_3F80_0000, 0, 0, 0);
    idle(LAT - 1);
    tick(0, 0, 0, 0, 0, 0, 1, 0);
    chk("acc_first", 64'(fflags_acc_o), 64'h10);
    tick(0, 0, 0, 0, 0, 0, 1, 0);
    chk("acc_clr_with_v", 64'(fflags_acc_o), 64'h10);
    idle(1);
    chk("acc_lone_clr", 64'(fflags_acc_o), 64'h0);

    // Reset with two ops in flight, then fclass(-inf)
    tick(1, 4, 0, 64'h1, 64'h2, 0, 0, 0);
    tick(1, 4, 0, 64'h3, 64'h4, 0, 0, 0);
    tick(1, 4, 0, 64'h5, 64'h6, 0, 0, 1);
    seen = 0;
    for (int i = 0; i < LAT + 1; i++) begin
      idle(1);
      seen += int'(v_o);
    end
    chk("reset_kills", 64'(seen), 64'd0);
    tick(1, 8, 0, 64'hFFF0_0000_0000_0000, 0, 0, 0, 0);
    idle(LAT);
    chk("fclass_ninf", data_o, 64'h1);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      bit sp;
      sp = 1'($urandom);
      tick($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), sp, rand_val(sp), rand_val(sp),
           $urandom_range(0, 19) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
    end
    idle(LAT + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bp_be_pipe_aux_raw.md
# bp_be_pipe_aux_raw

Parametrised, pipelined successor to the backend FP auxiliary pipe. It executes the non-arithmetic FP instructions directly on raw IEEE-754 operands: FSGNJ/N/X, FMIN/FMAX, FEQ/FLT/FLE, FCLASS, FMV.X and FMV.F, in SP or DP. It adds three things the existing aux pipe does not have: a configurable latency with per-stage valid tracking, a pipeline flush, and a sticky fflags accumulator. It sits in the calculator beside the FMA pipe and feeds the FP and integer writeback paths.

## Interface
- latency_p, default 2: pipeline depth in cycles; legal values are 1 to 8.
- dword_width_p, default 64: datapath width; fixed by RV64.
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- v_i  in  1  issue valid. The pipe is always ready; there is no backpressure.
- fu_op_i  in  4  op select: 0 fsgnj, 1 fsgnjn, 2 fsgnjx, 3 fmin, 4 fmax, 5 feq, 6 flt, 7 fle, 8 fclass, 9 fmvi (F→X), 10 imvf (X→F). Codes 11–15 are illegal.
- ops_v_i  in  1  1 = single precision, 0 = double precision.
- rs1_i, rs2_i  in  64  raw operands. For imvf, rs1_i is the integer source.
- flush_i  in  1  kill every in-flight op.
- fflags_clr_i  in  1  clear the accumulator.
- v_o  out  1  result valid.
- data_o  out  64  result.
- int_not_fp_o  out  1  1 = route to the integer regfile; 0 = route to the FP regfile.
- fflags_o  out  5  {nv,dz,of,uf,nx} for this result.
- fflags_acc_o  out  5  sticky OR of fflags_o over all retired ops.

## Operation
- NaN unboxing applies when ops_v_i is set and the operand's bits [63:32] are not all ones. Such an operand is replaced by the SP canonical NaN 0x7FC00000. Unboxing applies to every op except fmvi and imvf.
- SP FP results are NaN-boxed: data_o = {32'hFFFFFFFF, result[31:0]}.
- Canonical NaN is SP 0xFFFFFFFF_7FC00000 and DP 0x7FF80000_00000000.
- Sign injection:
  - fsgnj: sign = sign(rs2).
  - fsgnjn: sign = ~sign(rs2).
  - fsgnjx: sign = sign(rs1) ^ sign(rs2).
  - All other bits come from rs1. NaN payloads are not canonicalised. No flags are raised.
- fmin/fmax:
  - Both operands NaN → canonical NaN.
  - Exactly one operand NaN → the other operand.
  - Otherwise IEEE compare, with -0 ordered below +0.
  - nv = either operand is an sNaN.
- feq is a quiet compare: nv only on an sNaN. flt/fle are signalling compares: nv on any NaN. Any NaN operand gives result 0. +0 equals -0. data_o = {63'b0, result}.
- fclass: data_o is a 10-bit one-hot, zero-extended. Bit order from bit 0: -inf, -norm, -sub, -0, +0, +sub, +norm, +inf, sNaN, qNaN. No flags.
- fmvi: SP gives sign-extended rs1[31:0]; DP gives rs1 unchanged. No flags.
- imvf: SP gives {32'hFFFFFFFF, rs1[31:0]}; DP gives rs1 unchanged. No flags.
- int_not_fp_o = 1 for feq, flt, fle, fclass and fmvi; 0 for all other ops.
- Illegal fu_op_i: the op retires with data_o = 0, fflags_o = 0 and int_not_fp_o = 1.
- dz, of, uf and nx are always 0 for every op.
- Accumulator, updated each cycle:
  - fflags_clr_i with v_o → acc = fflags_o.
  - fflags_clr_i alone → acc = 0.
  - v_o alone → acc |= fflags_o.

## Timing
- Computation completes in the first stage. Stages 2 through latency_p are retiming registers, each carrying {valid, data, int_not_fp, fflags}.
- An op issued with v_i high in cycle t produces v_o high in cycle t + latency_p, unless it is flushed.
- Throughput is one op per cycle. Back-to-back ops retire back to back, in order.
- flush_i in cycle t:
  - clears every stage valid at the end of cycle t;
  - drops any v_i presented in cycle t;
  - v_o is 0 in cycles t+1 through t+latency_p for those killed ops.
  - v_i in cycle t+1 is accepted normally.
- v_o in cycle t, for an op already in the last stage, is not suppressed by a flush_i in that same cycle t.
- When v_o = 0, data_o, fflags_o and int_not_fp_o are driven to 0.
- Reset:
  - all stage valids, v_o, data_o, fflags_o and int_not_fp_o are 0 on the cycle after reset_i is sampled high;
  - fflags_acc_o resets to 0;
  - reset mid-operation discards all in-flight ops;
  - v_i is ignored while reset_i is high.
- fflags_acc_o is registered: it reflects the v_o of cycle t in cycle t+1.

## Test plan
- Case 1, latency_p=2, DP fmin with rs1=0x8000000000000000 (-0) and rs2=0 (+0) issued in cycle 5:
  - cycle 7: v_o=1, data_o=0x8000000000000000, fflags_o=0, int_not_fp_o=0.
- Case 2, SP feq with rs1=0xFFFFFFFF_7F800001 (sNaN) and rs2=0xFFFFFFFF_3F800000:
  - data_o=0, fflags_o=5'b10000.
  - The same operands through flt also give nv=1.
- Case 3, SP fsgnjn with rs1=0x00000000_3F800000 (unboxed) and rs2=0xFFFFFFFF_00000000:
  - rs1 is replaced by the canonical NaN, so data_o=0xFFFFFFFF_FFC00000.
- Case 4, latency_p=3, ops issued in cycles 1–4 and flush_i in cycle 3:
  - only the cycle-4 op retires, in cycle 7;
  - the cycle-3 op is dropped and the cycle-1/2 ops are killed in flight, so v_o=0 in cycles 4–6.
- Case 5, two flt ops on NaN operands retiring in consecutive cycles, with fflags_clr_i asserted together with the second v_o:
  - fflags_acc_o reads 5'b10000 after each retirement, and reads 0 after a lone clear.
- Case 6, reset_i asserted with 2 ops in flight:
  - no v_o follows; all outputs are 0;
  - an fclass of 0xFFF0000000000000 issued after reset returns data_o=0x1.
